// File: rtl/rv32_fwd_pkg.sv
// Shared encodings and shadow-stage bundle for the RV32I hazard/forwarding unit.
// Forwarding mode is selected by HAZARD_FWD_CTRL_FORWARDING_EN.
package rv32_fwd_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [2:0] OPB_RS2   = 3'b000;
  localparam logic [2:0] OPB_IMM   = 3'b001;
  localparam logic [2:0] OPB_PC    = 3'b010;
  localparam logic [2:0] OPB_EXMEM = 3'b110;
  localparam logic [2:0] OPB_MEMWB = 3'b101;

  localparam logic [1:0] ALUSRC_RS2 = 2'b00;
  localparam logic [1:0] ALUSRC_IMM = 2'b01;
  localparam logic [1:0] ALUSRC_PC  = 2'b10;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     reg_write;
    logic     mem_read;
  } shadow_t;

  // The younger producer (EX) always wins.
  function automatic logic [1:0] fwd_pick(
    input logic ex_hit,
    input logic mem_hit
  );
    if (ex_hit)       return FWD_EXMEM;
    else if (mem_hit) return FWD_MEMWB;
    else              return FWD_REG;
  endfunction

  function automatic logic [2:0] opb_of_fwd(
    input logic [1:0] f
  );
    unique case (1'b1)
      (f == FWD_EXMEM): return OPB_EXMEM;
      (f == FWD_MEMWB): return OPB_MEMWB;
      default:          return OPB_RS2;
    endcase
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one shadow stage against one ID source register.
// Pure combinational; hit requires a live, writing, nonzero producer.
module hazard_match
  import rv32_fwd_pkg::*;
(
  input  shadow_t  stage_i,
  input  reg_idx_t rs_i,
  input  logic     used_i,
  output logic     hit_o,
  output logic     load_hit_o
);

  assign hit_o = used_i
               & stage_i.valid
               & stage_i.reg_write
               & (stage_i.rd != 5'd0)
               & (stage_i.rd == rs_i);

  assign load_hit_o = hit_o & stage_i.mem_read;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding control at the ID/EX boundary.
// Define HAZARD_FWD_CTRL_FORWARDING_EN for full forwarding; else interlock-only.
module hazard_fwd_ctrl
  import rv32_fwd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic [1:0] id_alu_src,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] ex_sel_ForwardA,
  output logic [2:0] ex_sel_ForwardB,
  output logic [1:0] ex_sel_ForwardS,
  output logic       ex_bubble
);

  shadow_t    ex_q, ex_d, mem_q;
  logic [1:0] sel_a_q, sel_a_d;
  logic [2:0] sel_b_q, sel_b_d;
  logic [1:0] sel_s_q, sel_s_d;
  logic       bubble_q, bubble_d;

  logic ex_hit1, ex_ld1, ex_hit2, ex_ld2;
  logic mem_hit1, mem_ld1, mem_hit2, mem_ld2;
  logic use1, use2;
  logic stall_raw, kill;
  logic [1:0] fwd_a, fwd_s;
  logic unused_ld;

  assign use1 = id_valid & id_uses_rs1;
  assign use2 = id_valid & id_uses_rs2;

  hazard_match u_ex_rs1 (
    .stage_i    (ex_q),
    .rs_i       (id_rs1),
    .used_i     (use1),
    .hit_o      (ex_hit1),
    .load_hit_o (ex_ld1)
  );

  hazard_match u_ex_rs2 (
    .stage_i    (ex_q),
    .rs_i       (id_rs2),
    .used_i     (use2),
    .hit_o      (ex_hit2),
    .load_hit_o (ex_ld2)
  );

  hazard_match u_mem_rs1 (
    .stage_i    (mem_q),
    .rs_i       (id_rs1),
    .used_i     (use1),
    .hit_o      (mem_hit1),
    .load_hit_o (mem_ld1)
  );

  hazard_match u_mem_rs2 (
    .stage_i    (mem_q),
    .rs_i       (id_rs2),
    .used_i     (use2),
    .hit_o      (mem_hit2),
    .load_hit_o (mem_ld2)
  );

  assign unused_ld = ^{mem_ld1, mem_ld2, ex_ld1, ex_ld2};

  always_comb begin
`ifdef HAZARD_FWD_CTRL_FORWARDING_EN
    stall_raw = ex_ld1 | ex_ld2;
    fwd_a     = fwd_pick(ex_hit1, mem_hit1);
    fwd_s     = fwd_pick(ex_hit2, mem_hit2);
`else
    stall_raw = ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2;
    fwd_a     = FWD_REG;
    fwd_s     = FWD_REG;
`endif
  end

  // Flush wins: the ID instruction is discarded, so nothing to hold.
  assign stall = stall_raw & ~flush;
  assign kill  = stall_raw | flush | ~id_valid;

  always_comb begin
    ex_d     = '0;
    sel_a_d  = FWD_REG;
    sel_b_d  = OPB_RS2;
    sel_s_d  = FWD_REG;
    bubble_d = 1'b1;
    if (!kill) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      sel_a_d        = fwd_a;
      sel_s_d        = fwd_s;
      bubble_d       = 1'b0;
      unique case (1'b1)
        (id_alu_src == ALUSRC_IMM): sel_b_d = OPB_IMM;
        (id_alu_src == ALUSRC_PC):  sel_b_d = OPB_PC;
        (id_alu_src == ALUSRC_RS2): sel_b_d = opb_of_fwd(fwd_s);
        default:                    sel_b_d = OPB_RS2;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= '0;
      mem_q    <= '0;
      sel_a_q  <= FWD_REG;
      sel_b_q  <= OPB_RS2;
      sel_s_q  <= FWD_REG;
      bubble_q <= 1'b1;
    end else begin
      mem_q    <= ex_q;
      ex_q     <= ex_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      sel_s_q  <= sel_s_d;
      bubble_q <= bubble_d;
    end
  end

  assign ex_sel_ForwardA = sel_a_q;
  assign ex_sel_ForwardB = sel_b_q;
  assign ex_sel_ForwardS = sel_s_q;
  assign ex_bubble       = bubble_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Randomized bench for hazard_fwd_ctrl against an issue-history model.
// Follows HAZARD_FWD_CTRL_FORWARDING_EN the same way the design does.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic [1:0] id_alu_src = '0;
  logic       flush = 1'b0;
  logic       stall;
  logic [1:0] ex_sel_ForwardA, ex_sel_ForwardS;
  logic [2:0] ex_sel_ForwardB;
  logic       ex_bubble;

  hazard_fwd_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_alu_src      (id_alu_src),
    .flush           (flush),
    .stall           (stall),
    .ex_sel_ForwardA (ex_sel_ForwardA),
    .ex_sel_ForwardB (ex_sel_ForwardB),
    .ex_sel_ForwardS (ex_sel_ForwardS),
    .ex_bubble       (ex_bubble)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rd;
    bit w;
    bit ld;
  } slot_t;

  // hist[0]: what entered EX last cycle; hist[1]: the one before (MEM).
  slot_t hist [2];
  int    exp_a, exp_b, exp_s, exp_bub;
  int    errors = 0, checks = 0;
  bit    last_stall;
  int    stall_run;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic int age_hit(input int rs, input bit used);
    for (int a = 0; a < 2; a++)
      if (used && hist[a].v && hist[a].w && hist[a].rd != 0 && hist[a].rd == rs)
        return a;
    return -1;
  endfunction

  function automatic int code_of(input int age);
    return (age == 0) ? 2 : (age == 1) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 2; a++) hist[a] = '{0, 0, 0, 0};
    exp_a = 0; exp_b = 0; exp_s = 0; exp_bub = 1;
  endtask

  task automatic check_regs();
    check("selA", int'(ex_sel_ForwardA), exp_a);
    check("selB", int'(ex_sel_ForwardB), exp_b);
    check("selS", int'(ex_sel_ForwardS), exp_s);
    check("bubble", int'(ex_bubble), exp_bub);
  endtask

  // Entered at posedge+1; leaves at the next posedge+1.
  task automatic step(
    input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
    input int rd, input bit w, input bit ld, input int alu, input bit fl
  );
    int h1, h2, fa, fs;
    bit st;
    slot_t nw;
    check_regs();
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_rd = 5'(rd);
    id_reg_write = w; id_mem_read = ld; id_alu_src = 2'(alu); flush = fl;
    #1;
    h1 = age_hit(rs1, v && u1);
    h2 = age_hit(rs2, v && u2);
`ifdef HAZARD_FWD_CTRL_FORWARDING_EN
    st = hist[0].ld && (h1 == 0 || h2 == 0);
    fa = code_of(h1);
    fs = code_of(h2);
`else
    st = (h1 >= 0) || (h2 >= 0);
    fa = 0;
    fs = 0;
`endif
    st = st && !fl;
    check("stall", int'(stall), int'(st));
    last_stall = st;
    if (st || fl || !v) begin
      nw = '{0, 0, 0, 0};
      exp_a = 0; exp_b = 0; exp_s = 0; exp_bub = 1;
    end else begin
      nw = '{1, rd, w, ld};
      exp_a = fa; exp_s = fs; exp_bub = 0;
      case (alu)
        1: exp_b = 1;
        2: exp_b = 2;
        3: exp_b = 0;
        default: exp_b = (fs == 2) ? 6 : (fs == 1) ? 5 : 0;
      endcase
    end
    hist[1] = hist[0];
    hist[0] = nw;
    @(posedge clk); #1;
  endtask

  // Hold one ID instruction until the model stops stalling it.
  task automatic issue(
    input int rs1, input int rs2, input bit u1, input bit u2,
    input int rd, input bit w, input bit ld, input int alu
  );
    stall_run = 0;
    do begin
      step(1, rs1, rs2, u1, u2, rd, w, ld, alu, 0);
      if (last_stall) stall_run++;
    end while (last_stall && stall_run < 4);
    check("stall_bound", int'(stall_run < 4), 1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_stall", int'(stall), 0);
    check_regs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // add x5; add x6,x5,x1
    issue(1, 2, 1, 1, 5, 1, 0, 0);
    issue(5, 1, 1, 1, 6, 1, 0, 0);
`ifdef HAZARD_FWD_CTRL_FORWARDING_EN
    check("b2b_stalls", stall_run, 0);
`else
    check("b2b_stalls", stall_run, 2);
`endif
    // add x5; nop; sub x7,x1,x5
    issue(1, 2, 1, 1, 5, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 5, 1, 1, 7, 1, 0, 0);
`ifndef HAZARD_FWD_CTRL_FORWARDING_EN
    check("gap_stalls", stall_run, 1);
`endif
    // lw x5; add x6,x5,x5
    issue(1, 0, 1, 0, 5, 1, 1, 1);
    issue(5, 5, 1, 1, 6, 1, 0, 0);
`ifdef HAZARD_FWD_CTRL_FORWARDING_EN
    check("lu_stalls", stall_run, 1);
`endif
    // x0 destination never forwards; addi ignores rs2 match; sw data fwd
    issue(1, 2, 1, 1, 0, 1, 0, 0);
    issue(0, 0, 1, 1, 3, 1, 0, 0);
    issue(1, 3, 1, 1, 4, 1, 0, 1);
    issue(1, 4, 1, 1, 0, 0, 0, 1);
    // lw x5 then dependent with flush; then reset mid-stall
    issue(1, 0, 1, 0, 5, 1, 1, 1);
    step(1, 5, 5, 1, 1, 6, 1, 0, 0, 1);
    issue(1, 0, 1, 0, 5, 1, 1, 1);
    step(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    pulse_reset();
    step(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      step($urandom_range(0, 7) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3),
           $urandom_range(0, 7) == 0);
    end
    check_regs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
